// File: rtl/hyb_accum_pkg.sv
// Shared types and default sizes for the hybrid (PPM) redundant accumulator controller.
package hyb_accum_pkg;

   localparam int unsigned DefWidth  = 16;
   localparam int unsigned DefCountW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StConvert,
      StDone
   } state_e;

endpackage

// File: rtl/hyb_ppm_row.sv
// Combinational row of radix-2 PPM cells: per bit xp + y - xn = 2t - u, giving a
// carry-free redundant sum sp - sn == xp + y - xn (mod 2**WIDTH).
module hyb_ppm_row #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] xp_i,
   input  logic [WIDTH-1:0] xn_i,
   input  logic [WIDTH-1:0] y_i,
   output logic [WIDTH-1:0] sp_o,
   output logic [WIDTH-1:0] sn_o
);

   logic [WIDTH-1:0] t;

   always_comb begin
      // t is set when the cell value is 1 or 2, u is the parity of the cell value
      t    = (xp_i & y_i) | (xp_i & ~xn_i) | (y_i & ~xn_i);
      sn_o = xp_i ^ xn_i ^ y_i;
      sp_o = {t[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/hyb_accum_ctrl.sv
// Accumulates N operands carry-free into a redundant acc_p/acc_n pair, then resolves it.
// Optional overflow flag (shadow binary accumulator) when OVERFLOW_FLAG_EN is defined.
module hyb_accum_ctrl
   import hyb_accum_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned COUNT_W = DefCountW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_ops,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
`ifdef OVERFLOW_FLAG_EN
   output logic               ovf,
`endif
   output logic               busy
);

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0]   acc_p_q, acc_p_d;
   logic [WIDTH-1:0]   acc_n_q, acc_n_d;
   logic [WIDTH-1:0]   out_sum_q, out_sum_d;
   logic [WIDTH-1:0]   row_sp, row_sn;
   logic               transfer;

   hyb_ppm_row #(
      .WIDTH (WIDTH)
   ) u_row (
      .xp_i (acc_p_q),
      .xn_i (acc_n_q),
      .y_i  (in_data),
      .sp_o (row_sp),
      .sn_o (row_sn)
   );

   assign in_ready  = (state_q == StAccum);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_sum   = out_sum_q;
   assign transfer  = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_p_d     = acc_p_q;
      acc_n_d     = acc_n_q;
      out_sum_d   = out_sum_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = num_ops;
               acc_p_d     = '0;
               acc_n_d     = '0;
               state_d     = (num_ops == '0) ? StConvert : StAccum;
            end
         end
         StAccum: begin
            if (transfer) begin
               acc_p_d     = row_sp;
               acc_n_d     = row_sn;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = StConvert;
               end
            end
         end
         StConvert: begin
            out_sum_d = acc_p_q - acc_n_q;
            state_d   = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         acc_p_q     <= '0;
         acc_n_q     <= '0;
         out_sum_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_p_q     <= acc_p_d;
         acc_n_q     <= acc_n_d;
         out_sum_q   <= out_sum_d;
      end
   end

`ifdef OVERFLOW_FLAG_EN
   localparam int unsigned ShW = WIDTH + COUNT_W;

   logic [ShW-1:0] shadow_q, shadow_d;
   logic           ovf_q, ovf_d;

   always_comb begin
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      if ((state_q == StIdle) && start) begin
         shadow_d = '0;
         ovf_d    = 1'b0;
      end else if (transfer) begin
         shadow_d = shadow_q + ShW'(in_data);
      end else if (state_q == StConvert) begin
         ovf_d = |shadow_q[ShW-1 -: COUNT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_hyb_accum_ctrl.sv
// Bench for hyb_accum_ctrl: directed jobs with literal expectations plus random jobs,
// all checked every cycle against a job-level arithmetic model.
module tb_hyb_accum_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_ops;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          busy;
`ifdef OVERFLOW_FLAG_EN
   logic          ovf;
`endif

   hyb_accum_ctrl #(
      .WIDTH   (W),
      .COUNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_ops   (num_ops),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
`ifdef OVERFLOW_FLAG_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Job-level model: phase 0 idle, 1 collecting, 2 resolving, 3 presenting result.
   int           m_phase = 0;
   int           m_left  = 0;
   logic [W-1:0] m_sum   = '0;
   logic [W-1:0] m_res   = '0;
   longint       m_big   = 0;
   bit           m_ovf   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_left = 0; m_sum = '0; m_res = '0; m_big = 0; m_ovf = 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_sum = '0; m_big = 0; m_ovf = 1'b0; m_left = int'(num_ops);
               m_phase = (num_ops == 0) ? 2 : 1;
            end
            1: if (in_valid) begin
               m_sum = m_sum + in_data;
               m_big = m_big + longint'(in_data);
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            2: begin
               m_res = m_sum;
               m_ovf = (m_big >= 64'd65536);
               m_phase = 3;
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [W-1:0] diff;
         diff = dut.acc_p_q - dut.acc_n_q;
         check("busy", 32'(busy), 32'(m_phase != 0));
         check("in_ready", 32'(in_ready), 32'(m_phase == 1));
         check("out_valid", 32'(out_valid), 32'(m_phase == 3));
         check("out_sum", 32'(out_sum), 32'(m_res));
         check("acc_p_minus_acc_n", 32'(diff), 32'(m_sum));
`ifdef OVERFLOW_FLAG_EN
         if (m_phase == 3) check("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_job(input int n);
      start = 1'b1; num_ops = CW'(n);
      tick();
      start = 1'b0; num_ops = CW'($urandom);
   endtask

   task automatic send(input logic [W-1:0] v);
      in_valid = 1'b1; in_data = v;
      tick();
      in_valid = 1'b0; in_data = W'($urandom);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_after_handshake", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_ops = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_out_sum", 32'(out_sum), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Three back-to-back operands.
      begin_job(3);
      check("busy_after_start", 32'(busy), 32'd1);
      send(16'd5); send(16'd7); send(16'd9);
      check("no_valid_1_after_last", 32'(out_valid), 32'd0);
      tick();
      check("valid_2_after_last", 32'(out_valid), 32'd1);
      check("sum_5_7_9", 32'(out_sum), 32'd21);
      handshake();
      check("sum_retained_in_idle", 32'(out_sum), 32'd21);

      // Empty job.
      begin_job(0);
      check("empty_no_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("empty_valid", 32'(out_valid), 32'd1);
      check("empty_sum", 32'(out_sum), 32'd0);
      handshake();

      // Wrapping job with gaps, then a stalled sink with ignored start pulses.
      begin_job(2);
      tick(); tick();
      send(16'hFFFF);
      tick();
      send(16'h0002);
      tick();
      check("wrap_sum", 32'(out_sum), 32'h0001);
`ifdef OVERFLOW_FLAG_EN
      check("wrap_ovf", 32'(ovf), 32'd1);
`endif
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; num_ops = 8'd7;
         tick();
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_sum", 32'(out_sum), 32'h0001);
      end
      start = 1'b0;
      handshake();

      // Reset mid-job abandons it.
      begin_job(4);
      send(16'd100); send(16'd200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      begin_job(2);
      send(16'd1); send(16'd1);
      tick();
      check("after_rst_sum", 32'(out_sum), 32'd2);
      handshake();

      // Random jobs with random source/sink pacing.
      for (int j = 0; j < 30; j++) begin
         int budget;
         begin_job((j % 5 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)));
         budget = 0;
         while (m_phase != 0 && budget < 2000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = W'($urandom);
            out_ready = ($urandom % 3) == 0;
            start     = ($urandom % 8) == 0;
            if (m_phase == 3 && out_ready) start = 1'b0;
            tick();
            budget++;
         end
         in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
         check("random_job_completes", 32'(budget < 2000), 32'd1);
         tick();
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
